// File: rtl/tcp_tx_pkg.sv
// Shared definitions for the TCP TX word serializer: byte width, FSM state
// encoding and the byte-index width helper.
package tcp_tx_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_WORD_BYTES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Byte index width; a one-byte word still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_WORD_BYTES);

endpackage

// File: rtl/tcp_tx_word_serializer.sv
// Pops words from an FWFT FIFO and writes them byte by byte to the SiTCP TX port.
// Optional completed-word counter on WORD_CNT when TCP_TX_WORD_CNT_EN is defined.
module tcp_tx_word_serializer
    import tcp_tx_pkg::*;
#(
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                         BUS_CLK,
    input  logic                         BUS_RST,
    input  logic                         ENABLE,
    input  logic                         FIFO_EMPTY,
    input  logic [BYTE_W*WORD_BYTES-1:0] FIFO_DATA,
    output logic                         FIFO_READ,
    input  logic                         TCP_TX_FULL,
    output logic                         TCP_TX_WR,
    output logic [BYTE_W-1:0]            TCP_TX_DATA,
`ifdef TCP_TX_WORD_CNT_EN
    output logic [31:0]                  WORD_CNT,
`endif
    output logic                         BUSY
);

    localparam int                 IDX_W    = idx_width(WORD_BYTES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORD_BYTES - 1);

    // Handshakes: a FIFO pop happens in the cycle FIFO_READ is high (only when
    // FIFO_EMPTY is low); a byte is accepted by SiTCP in the cycle TCP_TX_WR is
    // high, which is only ever driven while TCP_TX_FULL is low.

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [BYTE_W*WORD_BYTES-1:0]    word_q, word_d;

    logic tx_wr;
    logic last_wr;
    logic load;
    logic [BYTE_W-1:0] tx_data;

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        tx_data = '0;

        tx_wr   = (state_q == SEND) && !TCP_TX_FULL;
        last_wr = tx_wr && (idx_q == LAST_IDX);
        // A reload is only legal from IDLE or on the write of the final byte,
        // which gives back-to-back words with no bubble.
        load    = !BUS_RST && ENABLE && !FIFO_EMPTY &&
                  ((state_q == IDLE) || last_wr);

        if (load) begin
            word_d  = FIFO_DATA;
            idx_d   = '0;
            state_d = SEND;
        end else if (last_wr) begin
            idx_d   = '0;
            state_d = IDLE;
        end else if (tx_wr) begin
            idx_d   = idx_q + IDX_W'(1);
        end

        // Output byte comes only from the held word, never from FIFO_DATA.
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (idx_q == IDX_W'(LSB_FIRST ? i : (WORD_BYTES - 1 - i))) begin
                tx_data = word_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign FIFO_READ   = load;
    assign TCP_TX_WR   = tx_wr;
    assign TCP_TX_DATA = tx_data;
    assign BUSY        = (state_q == SEND);

`ifdef TCP_TX_WORD_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (last_wr) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign WORD_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_tcp_tx_word_serializer.sv
// Bench for tcp_tx_word_serializer: LSB-first and MSB-first instances share
// stimulus and are checked every cycle against a queue-based byte-stream model.
module tb_tcp_tx_word_serializer;

  localparam int WB = 4;

  // ---------------- clock / reset / DUT signals ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic [8*WB-1:0] fifo_data;
  logic          tx_full;
  logic          read_l, read_m, wr_l, wr_m, busy_l, busy_m;
  logic [7:0]    data_l, data_m;
`ifdef TCP_TX_WORD_CNT_EN
  logic [31:0]   cnt_l, cnt_m;
`endif

  always #5 clk = ~clk;

  tcp_tx_word_serializer #(.WORD_BYTES(WB), .LSB_FIRST(1'b1)) dut_l (
    .BUS_CLK(clk), .BUS_RST(rst), .ENABLE(enable), .FIFO_EMPTY(fifo_empty),
    .FIFO_DATA(fifo_data), .FIFO_READ(read_l), .TCP_TX_FULL(tx_full),
    .TCP_TX_WR(wr_l), .TCP_TX_DATA(data_l),
`ifdef TCP_TX_WORD_CNT_EN
    .WORD_CNT(cnt_l),
`endif
    .BUSY(busy_l)
  );

  tcp_tx_word_serializer #(.WORD_BYTES(WB), .LSB_FIRST(1'b0)) dut_m (
    .BUS_CLK(clk), .BUS_RST(rst), .ENABLE(enable), .FIFO_EMPTY(fifo_empty),
    .FIFO_DATA(fifo_data), .FIFO_READ(read_m), .TCP_TX_FULL(tx_full),
    .TCP_TX_WR(wr_m), .TCP_TX_DATA(data_m),
`ifdef TCP_TX_WORD_CNT_EN
    .WORD_CNT(cnt_m),
`endif
    .BUSY(busy_m)
  );

  // ---------------- model state / scoreboard ----------------
  logic [8*WB-1:0] fifo_q[$];     // upstream FIFO contents
  logic [7:0]      exp_q[$];      // bytes still owed by the LSB-first instance
  logic [7:0]      exp_msb_q[$];  // bytes still owed by the MSB-first instance
  logic [31:0]     model_cnt;
  int              tests_run    = 0;
  int              tests_failed = 0;
  int              obs_reads, obs_writes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [8*WB-1:0] w);
    fifo_q.push_back(w);
  endtask

  // One clock: present FIFO head, compare every output with the model,
  // advance the model across the posedge, return at the next negedge.
  task automatic cycle();
    logic e_busy, e_wr, e_rd;
    logic [8*WB-1:0] w;
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? $urandom : fifo_q[0];
    #1;
    e_busy = (exp_q.size() != 0);
    e_wr   = e_busy && !tx_full;
    e_rd   = enable && !fifo_empty && (!e_busy || (e_wr && exp_q.size() == 1));
    chk("tx_wr_l", {31'd0, wr_l}, {31'd0, e_wr});
    chk("tx_wr_m", {31'd0, wr_m}, {31'd0, e_wr});
    chk("fifo_read_l", {31'd0, read_l}, {31'd0, e_rd});
    chk("fifo_read_m", {31'd0, read_m}, {31'd0, e_rd});
    chk("busy_l", {31'd0, busy_l}, {31'd0, e_busy});
    chk("busy_m", {31'd0, busy_m}, {31'd0, e_busy});
    if (e_wr) begin
      chk("tx_data_l", {24'd0, data_l}, {24'd0, exp_q[0]});
      chk("tx_data_m", {24'd0, data_m}, {24'd0, exp_msb_q[0]});
    end
`ifdef TCP_TX_WORD_CNT_EN
    chk("word_cnt_l", cnt_l, model_cnt);
    chk("word_cnt_m", cnt_m, model_cnt);
`endif
    if (read_l) obs_reads++;
    if (wr_l)   obs_writes++;
    @(posedge clk);
    if (e_wr) begin
      void'(exp_q.pop_front());
      void'(exp_msb_q.pop_front());
      if (exp_q.size() == 0) model_cnt = model_cnt + 32'd1;
    end
    if (e_rd) begin
      w = fifo_q.pop_front();
      for (int b = 0; b < WB; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        exp_msb_q.push_back(w[8*(WB-1-b) +: 8]);
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_read"}, {30'd0, read_l, read_m}, 32'd0);
    chk({tag, "_wr"},   {30'd0, wr_l, wr_m}, 32'd0);
    chk({tag, "_busy"}, {30'd0, busy_l, busy_m}, 32'd0);
    chk({tag, "_data"}, {16'd0, data_l, data_m}, 32'd0);
`ifdef TCP_TX_WORD_CNT_EN
    chk({tag, "_cnt"},  cnt_l | cnt_m, 32'd0);
`endif
  endtask

  task automatic drain(input string tag);
    tx_full = 1'b0;
    enable  = 1'b1;
    for (int k = 0; k < 200 && (fifo_q.size() != 0 || exp_q.size() != 0); k++) cycle();
    chk(tag, fifo_q.size() + exp_q.size(), 32'd0);
    run(2);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; enable = 1'b0; tx_full = 1'b0;
    fifo_empty = 1'b1; fifo_data = '0; model_cnt = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    run(2);

    // single word, LSB instance gives D4 C3 B2 A1
    obs_reads = 0; obs_writes = 0;
    enable = 1'b1;
    push(32'hA1B2C3D4);
    run(7);
    chk("t1_reads", obs_reads, 32'd1);
    chk("t1_writes", obs_writes, 32'd4);

    // two words back to back, MSB instance gives 11..88
    obs_reads = 0; obs_writes = 0;
    push(32'h11223344);
    push(32'h55667788);
    run(11);
    chk("t2_reads", obs_reads, 32'd2);
    chk("t2_writes", obs_writes, 32'd8);
`ifdef TCP_TX_WORD_CNT_EN
    chk("cnt_three", cnt_l, 32'd3);
`endif

    // stall for 5 cycles after the second byte of DEADBEEF
    obs_reads = 0;
    push(32'hDEADBEEF);
    run(3);
    tx_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("stall_hold_l", {24'd0, data_l}, 32'h0000_00AD);
      chk("stall_hold_m", {24'd0, data_m}, 32'h0000_00BE);
    end
    tx_full = 1'b0;
    run(4);
    chk("t3_reads", obs_reads, 32'd1);

    // ENABLE drops after the first byte with a second word waiting
    obs_reads = 0;
    push(32'h01020304);
    push(32'h05060708);
    run(2);
    enable = 1'b0;
    run(6);
    chk("t4_reads_held", obs_reads, 32'd1);
    enable = 1'b1;
    run(1);
    chk("t4_reads_resume", obs_reads, 32'd2);
    run(5);

    // TCP_TX_FULL rises on the last byte while another word waits
    push(32'hCAFE0123);
    push(32'h89ABCDEF);
    run(4);
    tx_full = 1'b1;
    run(3);
    tx_full = 1'b0;
    drain("t5_drain");

    // asynchronous reset during byte 1; held word is lost
    push(32'h0F1E2D3C);
    push(32'h4B5A6978);
    run(2);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    exp_q.delete();
    exp_msb_q.delete();
    model_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    drain("t6_drain");

`ifdef TCP_TX_WORD_CNT_EN
    // counter wrap
    force dut_l.cnt_q = 32'hFFFF_FFFF;
    force dut_m.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut_l.cnt_q;
    release dut_m.cnt_q;
    model_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    push(32'h13572468);
    run(6);
    chk("cnt_wrap", cnt_l, 32'd0);
`endif

    // randomized traffic with random backpressure and enable
    for (int k = 0; k < 1500; k++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 3) == 0) push($urandom);
      tx_full = ($urandom_range(0, 3) == 0);
      enable  = ($urandom_range(0, 7) != 0);
      cycle();
    end
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
